// File: rtl/ccip_mmio_host.sv
// CCI-P style MMIO host: turns host read/write commands into AFU request strobes and collects tid-matched read responses.
// Optional read-response timeout is enabled by defining CCIP_MMIO_TIMEOUT_EN.
module ccip_mmio_host #(
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [15:0]    cmd_addr,
  input  logic [1:0]     cmd_len,
  input  logic [63:0]    cmd_wdata,
  output logic [27:0]    rx_c0_hdr,
  output logic [511:0]   rx_c0_data,
  output logic           rx_c0_mmioRdValid,
  output logic           rx_c0_mmioWrValid,
  input  logic [8:0]     tx_c2_tid,
  input  logic           tx_c2_mmioRdValid,
  input  logic [63:0]    tx_c2_data,
  output logic           rsp_valid,
  output logic [63:0]    rsp_data,
  output logic           rsp_err,
  output logic [15:0]    stale_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RSP = 2'd2, RESP = 2'd3} state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..1023");
  end

  state_e        state_q, state_d;
  logic [8:0]    tid_q, tid_d;
  logic [8:0]    out_tid_q, out_tid_d;
  logic          wr_q, wr_d;
  logic          len4_q, len4_d;
  logic [63:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic [27:0]   hdr_q, hdr_d;
  logic [63:0]   data_q, data_d;
  logic          rdv_q, rdv_d;
  logic          wrv_q, wrv_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [63:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   stale_q, stale_d;
  logic          rsp_match_s;
  logic          illegal_s;
`ifdef CCIP_MMIO_TIMEOUT_EN
  // rsp_valid trails RESP by one registered stage, so the timeout is decided one
  // cycle early to land the response exactly TIMEOUT_CYCLES after WAIT_RSP entry.
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 2);
  logic [9:0]    cnt_q, cnt_d;
`endif

  assign rsp_match_s = tx_c2_mmioRdValid && (state_q == WAIT_RSP) && (tx_c2_tid == out_tid_q);
  assign illegal_s   = cmd_len[1] || ((cmd_len == 2'b01) && cmd_addr[0]);

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    tid_d       = tid_q;
    out_tid_d   = out_tid_q;
    wr_d        = wr_q;
    len4_d      = len4_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    hdr_d       = 28'd0;
    data_d      = 64'd0;
    rdv_d       = 1'b0;
    wrv_d       = 1'b0;
    rsp_valid_d = (state_q == RESP);
    if (state_q == RESP) begin
      rsp_data_d = res_data_q;
      rsp_err_d  = res_err_q;
    end else begin
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
    end
    if (tx_c2_mmioRdValid && !rsp_match_s && (stale_q != 16'hFFFF)) begin
      stale_d = stale_q + 16'd1;
    end else begin
      stale_d = stale_q;
    end
`ifdef CCIP_MMIO_TIMEOUT_EN
    cnt_d = 10'd0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d   = cmd_write;
          len4_d = (cmd_len == 2'b00);
          if (illegal_s) begin
            state_d    = RESP;
            res_err_d  = 1'b1;
            res_data_d = 64'd0;
          end else begin
            state_d = ISSUE;
            hdr_d   = {cmd_addr, cmd_len, 1'b0, tid_q};
            data_d  = cmd_write ? cmd_wdata : 64'd0;
            rdv_d   = !cmd_write;
            wrv_d   = cmd_write;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          state_d   = WAIT_RSP;
          out_tid_d = tid_q;
          tid_d     = tid_q + 9'd1;
        end
      end
      WAIT_RSP: begin
        if (rsp_match_s) begin
          state_d    = RESP;
          res_err_d  = 1'b0;
          res_data_d = len4_q ? {32'd0, tx_c2_data[31:0]} : tx_c2_data;
        end
`ifdef CCIP_MMIO_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d    = RESP;
          res_err_d  = 1'b1;
          res_data_d = 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
`else
        else begin
          state_d = WAIT_RSP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tid_q       <= 9'd0;
      out_tid_q   <= 9'd0;
      wr_q        <= 1'b0;
      len4_q      <= 1'b0;
      res_data_q  <= 64'd0;
      res_err_q   <= 1'b0;
      hdr_q       <= 28'd0;
      data_q      <= 64'd0;
      rdv_q       <= 1'b0;
      wrv_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 64'd0;
      rsp_err_q   <= 1'b0;
      stale_q     <= 16'd0;
`ifdef CCIP_MMIO_TIMEOUT_EN
      cnt_q       <= 10'd0;
`endif
    end else begin
      state_q     <= state_d;
      tid_q       <= tid_d;
      out_tid_q   <= out_tid_d;
      wr_q        <= wr_d;
      len4_q      <= len4_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      rdv_q       <= rdv_d;
      wrv_q       <= wrv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      stale_q     <= stale_d;
`ifdef CCIP_MMIO_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready         = (state_q == IDLE);
  assign rx_c0_hdr         = hdr_q;
  assign rx_c0_data        = {448'd0, data_q};
  assign rx_c0_mmioRdValid = rdv_q;
  assign rx_c0_mmioWrValid = wrv_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign stale_cnt         = stale_q;

endmodule

// File: tb/tb_ccip_mmio_host.sv
// Directed + randomized bench for ccip_mmio_host with a transaction-level expectation model.
module tb_ccip_mmio_host;
  localparam int TO = 512;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [15:0]  cmd_addr;
  logic [1:0]   cmd_len;
  logic [63:0]  cmd_wdata;
  logic [27:0]  rx_c0_hdr;
  logic [511:0] rx_c0_data;
  logic         rx_c0_mmioRdValid, rx_c0_mmioWrValid;
  logic [8:0]   tx_c2_tid;
  logic         tx_c2_mmioRdValid;
  logic [63:0]  tx_c2_data;
  logic         rsp_valid, rsp_err;
  logic [63:0]  rsp_data;
  logic [15:0]  stale_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_tid  = 0;
  int exp_stale = 0;

  ccip_mmio_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rx_c0_hdr(rx_c0_hdr), .rx_c0_data(rx_c0_data),
    .rx_c0_mmioRdValid(rx_c0_mmioRdValid), .rx_c0_mmioWrValid(rx_c0_mmioWrValid),
    .tx_c2_tid(tx_c2_tid), .tx_c2_mmioRdValid(tx_c2_mmioRdValid), .tx_c2_data(tx_c2_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .stale_cnt(stale_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A 4-byte read only returns the low word.
  function automatic logic [63:0] model_rdata(input logic [1:0] len, input logic [63:0] d);
    if (len == 2'b00) return d & 64'h0000_0000_FFFF_FFFF;
    return d;
  endfunction

  function automatic logic [27:0] model_hdr(input logic [15:0] a, input logic [1:0] l, input int t);
    logic [8:0] tt;
    tt = 9'(t % 512);
    return {a, l, 1'b0, tt};
  endfunction

  // Returns in the cycle right after acceptance.
  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick;
      n++;
    end
    check("cmd_ready_wait", 512'(cmd_ready), 512'(1'b1));
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_wdata = d;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic afu_rsp(input int tid, input logic [63:0] d);
    tx_c2_mmioRdValid = 1'b1;
    tx_c2_tid = 9'(tid % 512);
    tx_c2_data = d;
    tick;
    tx_c2_mmioRdValid = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d, input int delay);
    send_cmd(1'b0, a, l, 64'($urandom));
    check("rd_strobe", 512'(rx_c0_mmioRdValid), 512'(1'b1));
    check("rd_hdr", 512'(rx_c0_hdr), 512'(model_hdr(a, l, exp_tid)));
    repeat (delay) tick;
    afu_rsp(exp_tid, d);
    check("rd_rsp_early", 512'(rsp_valid), 512'(1'b0));
    tick;
    check("rd_rsp_valid", 512'(rsp_valid), 512'(1'b1));
    check("rd_rsp_err", 512'(rsp_err), 512'(1'b0));
    check("rd_rsp_data", 512'(rsp_data), 512'(model_rdata(l, d)));
    exp_tid = (exp_tid + 1) % 512;
  endtask

  initial begin
    logic [63:0] d;
    int n;
    int old_tid;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_len = 2'd0;
    cmd_wdata = 64'd0; tx_c2_tid = 9'd0; tx_c2_mmioRdValid = 1'b0; tx_c2_data = 64'd0;
    repeat (3) tick;
    reset_n = 1'b1;
    tick;

    check("rst_ready", 512'(cmd_ready), 512'(1'b1));
    check("rst_rsp_valid", 512'(rsp_valid), 512'(1'b0));
    check("rst_rsp_data", 512'(rsp_data), 512'(64'd0));
    check("rst_rsp_err", 512'(rsp_err), 512'(1'b0));
    check("rst_stale", 512'(stale_cnt), 512'(16'd0));
    check("rst_hdr", 512'(rx_c0_hdr), 512'(28'd0));
    check("rst_data", rx_c0_data, 512'd0);
    check("rst_strobes", 512'({rx_c0_mmioRdValid, rx_c0_mmioWrValid}), 512'(2'b00));

    // Write: one strobe cycle, header/data, no response, tid unchanged.
    send_cmd(1'b1, 16'h0010, 2'b01, 64'h1122334455667788);
    check("wr_strobe", 512'({rx_c0_mmioWrValid, rx_c0_mmioRdValid}), 512'(2'b10));
    check("wr_hdr", 512'(rx_c0_hdr), 512'(model_hdr(16'h0010, 2'b01, exp_tid)));
    check("wr_data", rx_c0_data, 512'(64'h1122334455667788));
    tick;
    check("wr_strobe_off", 512'(rx_c0_mmioWrValid), 512'(1'b0));
    check("wr_hdr_off", 512'(rx_c0_hdr), 512'(28'd0));
    check("wr_ready_after", 512'(cmd_ready), 512'(1'b1));
    check("wr_no_rsp", 512'(rsp_valid), 512'(1'b0));

    // 4B read, response after 5 cycles; then result must be held.
    do_read(16'h0020, 2'b00, 64'hAAAABBBBCCCCDDDD, 5);
    tick;
    check("hold_valid", 512'(rsp_valid), 512'(1'b0));
    check("hold_data", 512'(rsp_data), 512'(64'h00000000CCCCDDDD));

    // Illegal commands: no strobe, error response two cycles after acceptance.
    send_cmd(1'b0, 16'h0005, 2'b01, 64'd0);
    check("ill_strobe", 512'({rx_c0_mmioRdValid, rx_c0_mmioWrValid}), 512'(2'b00));
    check("ill_early", 512'(rsp_valid), 512'(1'b0));
    tick;
    check("ill_valid", 512'(rsp_valid), 512'(1'b1));
    check("ill_err", 512'(rsp_err), 512'(1'b1));
    send_cmd(1'b1, 16'h0040, 2'($urandom_range(2, 3)), 64'($urandom));
    check("ill2_strobe", 512'({rx_c0_mmioRdValid, rx_c0_mmioWrValid}), 512'(2'b00));
    tick;
    check("ill2_valid", 512'(rsp_valid), 512'(1'b1));
    check("ill2_err", 512'(rsp_err), 512'(1'b1));
    tick;
    check("ill2_err_hold", 512'(rsp_err), 512'(1'b1));

    // 8B read after errors: tid untouched by writes/illegal commands.
    do_read(16'h0108, 2'b01, {$urandom, $urandom}, 2);

    // Wrong tid during WAIT_RSP is stale, then the right one completes.
    d = {$urandom, $urandom};
    send_cmd(1'b0, 16'h0030, 2'b01, 64'd0);
    check("wt_hdr", 512'(rx_c0_hdr), 512'(model_hdr(16'h0030, 2'b01, exp_tid)));
    tick;
    afu_rsp(exp_tid + 1, 64'hDEAD_BEEF_0000_0000);
    exp_stale++;
    afu_rsp(exp_tid, d);
    check("wt_stale", 512'(stale_cnt), 512'(16'(exp_stale)));
    check("wt_early", 512'(rsp_valid), 512'(1'b0));
    tick;
    check("wt_valid", 512'(rsp_valid), 512'(1'b1));
    check("wt_data", 512'(rsp_data), 512'(d));
    exp_tid = (exp_tid + 1) % 512;

    // Response while idle is stale and does not disturb the FSM.
    afu_rsp(exp_tid, 64'd1);
    exp_stale++;
    tick;
    check("idle_stale", 512'(stale_cnt), 512'(16'(exp_stale)));
    check("idle_ready", 512'(cmd_ready), 512'(1'b1));
    check("idle_no_rsp", 512'(rsp_valid), 512'(1'b0));

    // Reset in the middle of an outstanding read.
    old_tid = exp_tid;
    send_cmd(1'b0, 16'h0050, 2'b01, 64'd0);
    tick;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_data", 512'(rsp_data), 512'(64'd0));
    check("arst_stale", 512'(stale_cnt), 512'(16'd0));
    check("arst_ready", 512'(cmd_ready), 512'(1'b1));
    exp_stale = 0;
    exp_tid = 0;
    tick;
    reset_n = 1'b1;
    tick;
    afu_rsp(old_tid, 64'd2);
    exp_stale++;
    tick;
    check("post_rst_stale", 512'(stale_cnt), 512'(16'(exp_stale)));
    check("post_rst_no_rsp", 512'(rsp_valid), 512'(1'b0));

    // 513 back-to-back reads: tids 0..511 then 0.
    for (int i = 0; i < 513; i++) begin
      do_read(16'($urandom_range(0, 16383) << 2), 2'($urandom_range(0, 1)),
              {$urandom, $urandom}, $urandom_range(1, 3));
    end

`ifdef CCIP_MMIO_TIMEOUT_EN
    // No AFU response: error response TO cycles after WAIT_RSP entry.
    send_cmd(1'b0, 16'h0060, 2'b01, 64'd0);
    tick;
    n = 0;
    while (!rsp_valid && n < 2000) begin
      tick;
      n++;
    end
    check("to_latency", 512'(n), 512'(TO));
    check("to_err", 512'(rsp_err), 512'(1'b1));
    check("to_data", 512'(rsp_data), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    exp_tid = (exp_tid + 1) % 512;
    // Matching response in the last waiting cycle wins over the timeout.
    d = {$urandom, $urandom};
    send_cmd(1'b0, 16'h0068, 2'b01, 64'd0);
    tick;
    repeat (TO - 2) tick;
    afu_rsp(exp_tid, d);
    tick;
    check("race_valid", 512'(rsp_valid), 512'(1'b1));
    check("race_err", 512'(rsp_err), 512'(1'b0));
    check("race_data", 512'(rsp_data), 512'(d));
    exp_tid = (exp_tid + 1) % 512;
`else
    // Without the timeout a read waits for as long as the AFU takes.
    d = {$urandom, $urandom};
    send_cmd(1'b0, 16'h0060, 2'b01, 64'd0);
    tick;
    n = 0;
    repeat (600) begin
      tick;
      if (rsp_valid) n++;
    end
    check("nto_no_rsp", 512'(n), 512'(0));
    afu_rsp(exp_tid, d);
    tick;
    check("nto_valid", 512'(rsp_valid), 512'(1'b1));
    check("nto_err", 512'(rsp_err), 512'(1'b0));
    check("nto_data", 512'(rsp_data), 512'(d));
    exp_tid = (exp_tid + 1) % 512;
`endif

    check("final_stale", 512'(stale_cnt), 512'(16'(exp_stale)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ccip_mmio_host.md
CCIP_MMIO_HOST -- requirements
Module: ccip_mmio_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 512, the MMIO read response timeout in clk cycles (range 2..1023).
REQ-002 SHALL have port clk, input, 1, the sole clock; every register is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1, host MMIO command valid.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_write, input, 1, 1 = MMIO write, 0 = MMIO read.
REQ-007 SHALL have port cmd_addr, input, 16, 4B-aligned MMIO address.
REQ-008 SHALL have port cmd_len, input, 2, access length: 00 = 4B, 01 = 8B, others illegal.
REQ-009 SHALL have port cmd_wdata, input, 64, write data.
REQ-010 SHALL have port rx_c0_hdr, output, 28, MMIO request header {address[15:0], length[1:0], rsvd, tid[8:0]}.
REQ-011 SHALL have port rx_c0_data, output, 512, write data; bits 63:0 carry the data and the upper bits are 0.
REQ-012 SHALL have port rx_c0_mmioRdValid, output, 1, MMIO read request strobe to the AFU.
REQ-013 SHALL have port rx_c0_mmioWrValid, output, 1, MMIO write request strobe to the AFU.
REQ-014 SHALL have port tx_c2_tid, input, 9, tid of the AFU read response.
REQ-015 SHALL have port tx_c2_mmioRdValid, input, 1, AFU read response valid.
REQ-016 SHALL have port tx_c2_data, input, 64, AFU read response data.
REQ-017 SHALL have port rsp_valid, output, 1, one-cycle pulse completing a read or a rejected command.
REQ-018 SHALL have port rsp_data, output, 64, read data.
REQ-019 SHALL have port rsp_err, output, 1, valid with rsp_valid; 1 = timeout or illegal command.
REQ-020 SHALL have port stale_cnt, output, 16, saturating count of ignored AFU responses.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-022 SHALL capture the command on acceptance: IDLE->ISSUE for a legal command; IDLE->RESP with rsp_err=1 for cmd_len>=2, or for cmd_len=01 with cmd_addr[0]=1; an illegal command SHALL issue nothing.
REQ-023 SHALL in ISSUE drive exactly one cycle of mmioWrValid (write) or mmioRdValid (read), with hdr and data stable in that cycle; outside ISSUE, hdr and data SHALL be 0.
REQ-024 SHALL move a write from ISSUE to IDLE with no rsp_valid; cmd_ready SHALL be high the next cycle.
REQ-025 SHALL move a read from ISSUE to WAIT_RSP using the current tid, then increment tid, wrapping 511->0; writes SHALL carry the current tid without incrementing it.
REQ-026 SHALL in WAIT_RSP accept a response only when tx_c2_mmioRdValid=1 and tx_c2_tid equals the outstanding tid, then go to RESP with rsp_err=0.
REQ-027 SHALL zero rsp_data[63:32] for a 4B read and pass all 64 bits for an 8B read.
REQ-028 SHALL increment stale_cnt, saturating at 0xFFFF, for any tx_c2_mmioRdValid in a state other than WAIT_RSP or with a mismatched tid; a stale response SHALL NOT affect the FSM.
REQ-029 SHALL in RESP pulse rsp_valid for one cycle, then return to IDLE; there is no backpressure.
REQ-030 SHALL keep rsp_data and rsp_err held until the next rsp_valid.

Reset
REQ-031 SHALL on reset_n=0, immediately and asynchronously, force: state=IDLE, tid=0, stale_cnt=0, timeout counter=0, all strobes=0, rsp_valid=0, rsp_data=0, rsp_err=0, rx_c0_hdr=0, rx_c0_data=0.
REQ-032 SHALL abandon an outstanding read on reset mid-operation; an AFU response arriving after reset SHALL count as stale.

Configuration
REQ-033 SHALL, with CCIP_MMIO_TIMEOUT_EN defined, count WAIT_RSP cycles in a 10-bit counter cleared on entry; reaching TIMEOUT_CYCLES SHALL go to RESP with rsp_err=1 and rsp_data=64'hFFFF_FFFF_FFFF_FFFF.
REQ-034 SHALL, if the matching response and the timeout occur in the same cycle, take the response (rsp_err=0).
REQ-035 SHALL, without CCIP_MMIO_TIMEOUT_EN, wait in WAIT_RSP indefinitely with no timeout counter; rsp_err SHALL then come only from illegal commands.

Verification
REQ-036 SHALL cover: write addr=0x0010, len=01, data=0x1122334455667788 -> one mmioWrValid cycle, hdr.address=0x0010, rx_c0_data[63:0]=0x1122334455667788, no rsp_valid.
REQ-037 SHALL cover: 4B read addr=0x0020; AFU returns the matching tid with data 0xAAAABBBBCCCCDDDD after 5 cycles -> rsp_valid, rsp_err=0, rsp_data=0x00000000CCCCDDDD.
REQ-038 SHALL cover: 513 back-to-back reads -> tids 0..511 then 0; the wrap is seen and every read completes.
REQ-039 SHALL cover: a response with a wrong tid during WAIT_RSP, then a correct one -> stale_cnt=1 and the read completes with the correct data.
REQ-040 SHALL cover: with CCIP_MMIO_TIMEOUT_EN and no AFU response -> rsp_valid exactly 512 cycles after WAIT_RSP entry, rsp_err=1, data all ones.
REQ-041 SHALL cover: a read with cmd_len=01 and addr=0x0005 -> no strobe, rsp_valid with rsp_err=1 two cycles after acceptance.
